sawtooth_gen: RTL and testbench

Upstream stage of led_dec. It generates the 8-bit sawtooth count and the active N1/N2 threshold pair that led_dec consumes on sawtooth_cntr_i, N1_data_i and N2_data_i. A configuration handshake accepts new N1/N2 values. New values are applied only at a sawtooth wrap, so one sawtooth period never mixes old and new thresholds.

---
 rtl/sawtooth_gen.sv | 99 +++++++++
 tb/tb_sawtooth_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sawtooth_gen.sv
// sawtooth_gen: 8-bit sawtooth counter with wrap-synchronised N1/N2 threshold config
// Ports: clc_i/rst_i clock and async active-high reset; run_i advance enable;
//        cfg_valid_i/cfg_ready_o/N1_i/N2_i config handshake; cfg_err_o rejected-config pulse;
//        sawtooth_cntr_o count; N1_data_o/N2_data_o active thresholds; wrap_o wrap pulse.
// Option: TRIANGLE_MODE_EN adds mode_i (1 = up/down triangle count, sampled at wrap).
module sawtooth_gen #(
    parameter int unsigned PRESC_DIV = 4,
    parameter logic [7:0]  CNT_MAX   = 8'd255
) (
    input  logic       clc_i,
    input  logic       rst_i,
    input  logic       run_i,
    input  logic       cfg_valid_i,
    output logic       cfg_ready_o,
    input  logic [7:0] N1_i,
    input  logic [7:0] N2_i,
`ifdef TRIANGLE_MODE_EN
    input  logic       mode_i,
`endif
    output logic       cfg_err_o,
    output logic [7:0] sawtooth_cntr_o,
    output logic [7:0] N1_data_o,
    output logic [7:0] N2_data_o,
    output logic       wrap_o
);
    localparam logic [15:0] PRESC_LAST = 16'(PRESC_DIV - 1);
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
    state_t state, state_n;
    logic [15:0] presc;
    logic [7:0] sh_n1, sh_n2, cnt_n;
    logic xfer, ok, active, tick, wrap_n;
`ifdef TRIANGLE_MODE_EN
    logic tri_r, down, tri_n, down_n;
`endif
    assign cfg_ready_o = state != PEND;
    always_comb begin
        xfer = cfg_valid_i & cfg_ready_o;
        ok = xfer & (N1_i <= N2_i);
        active = run_i & (state != IDLE);
        tick = active & (presc == PRESC_LAST);
`ifdef TRIANGLE_MODE_EN
        cnt_n = !tick ? sawtooth_cntr_o :
                (tri_r && (down || sawtooth_cntr_o == CNT_MAX)) ? sawtooth_cntr_o - 8'd1 :
                (sawtooth_cntr_o == CNT_MAX) ? 8'd0 : sawtooth_cntr_o + 8'd1;
`else
        cnt_n = !tick ? sawtooth_cntr_o :
                (sawtooth_cntr_o == CNT_MAX) ? 8'd0 : sawtooth_cntr_o + 8'd1;
`endif
        // CNT_MAX >= 1, so a ticked count only lands on 0 by wrapping
        wrap_n = tick & (cnt_n == 8'd0);
`ifdef TRIANGLE_MODE_EN
        tri_n = (wrap_n || state == IDLE) ? mode_i : tri_r;
        down_n = !(tick && tri_r) ? down : wrap_n ? 1'b0 : (sawtooth_cntr_o == CNT_MAX) ? 1'b1 : down;
`endif
        state_n = state == IDLE ? (ok ? RUN : IDLE) :
                  state == RUN  ? (ok ? PEND : RUN) :
                  (wrap_n ? RUN : PEND);
    end
    always_ff @(posedge clc_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clc_i or posedge rst_i) begin
        if (rst_i) begin
            presc <= '0;
            sawtooth_cntr_o <= '0;
            wrap_o <= 1'b0;
            cfg_err_o <= 1'b0;
            N1_data_o <= '0;
            N2_data_o <= '0;
            sh_n1 <= '0;
            sh_n2 <= '0;
`ifdef TRIANGLE_MODE_EN
            tri_r <= 1'b0;
            down <= 1'b0;
`endif
        end else begin
            presc <= !active ? presc : tick ? 16'd0 : presc + 16'd1;
            sawtooth_cntr_o <= cnt_n;
            wrap_o <= wrap_n;
            cfg_err_o <= xfer & (N1_i > N2_i);
`ifdef TRIANGLE_MODE_EN
            tri_r <= tri_n;
            down <= down_n;
`endif
            if (ok && state == IDLE) begin
                N1_data_o <= N1_i;
                N2_data_o <= N2_i;
            end else if (state == PEND && wrap_n) begin
                N1_data_o <= sh_n1;
                N2_data_o <= sh_n2;
            end
            // a transfer landing on a wrap edge in RUN is held for the following wrap
            if (ok && state == RUN) begin
                sh_n1 <= N1_i;
                sh_n2 <= N2_i;
            end
        end
    end
endmodule

// File: tb/tb_sawtooth_gen.sv
// tb_sawtooth_gen: randomized and directed check of sawtooth_gen against an elapsed-time model
module tb_sawtooth_gen;
    localparam int PD = 4;
    localparam int CM = 255;
    localparam int PERIOD = PD * (CM + 1);
    logic clk = 1'b0, rst = 1'b1, run = 1'b1, cfg_valid = 1'b0;
    logic [7:0] n1_in = '0, n2_in = '0;
    logic cfg_ready, cfg_err, wrap;
    logic [7:0] cnt, n1_out, n2_out;
    int n_vec = 0, n_err = 0;
    logic m_run = 0, m_pend = 0, m_wrap = 0, m_err = 0, xf, good;
    int m_e = 0;
    logic [7:0] m_n1 = 0, m_n2 = 0, m_s1 = 0, m_s2 = 0, hold;
    sawtooth_gen #(.PRESC_DIV(PD), .CNT_MAX(8'(CM))) dut (
        .clc_i(clk), .rst_i(rst), .run_i(run), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .N1_i(n1_in), .N2_i(n2_in), .cfg_err_o(cfg_err), .sawtooth_cntr_o(cnt),
        .N1_data_o(n1_out), .N2_data_o(n2_out), .wrap_o(wrap)
    );
    always #5 clk = ~clk;
    // model: count is elapsed running cycles / PD modulo CM+1; config swaps happen on period boundaries
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_run = 0; m_pend = 0; m_e = 0; m_wrap = 0; m_err = 0;
            m_n1 = 0; m_n2 = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            xf = cfg_valid && !m_pend;
            good = n1_in <= n2_in;
            m_err = xf && !good;
            m_wrap = 0;
            if (m_run && run) begin
                m_e++;
                m_wrap = (m_e % PERIOD) == 0;
            end
            if (m_wrap && m_pend) begin
                m_n1 = m_s1; m_n2 = m_s2; m_pend = 0;
            end
            if (xf && good) begin
                if (!m_run) begin
                    m_n1 = n1_in; m_n2 = n2_in; m_run = 1; m_e = 0;
                end else begin
                    m_s1 = n1_in; m_s2 = n2_in; m_pend = 1;
                end
            end
        end
    end
    always @(negedge clk) begin
        logic [26:0] exp_v, act_v;
        exp_v = {8'((m_e / PD) % (CM + 1)), m_wrap, m_err, !m_pend, m_n1, m_n2};
        act_v = {cnt, wrap, cfg_err, cfg_ready, n1_out, n2_out};
        n_vec++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL cycle_cmp t=%0t {cnt,wrap,err,ready,n1,n2} got %h expected %h", $time, act_v, exp_v);
        end
    end
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        cfg_valid = 1; n1_in = a; n2_in = b;
        @(negedge clk);
        cfg_valid = 0;
    endtask
    task automatic wait_cnt(input logic [7:0] v);
        int k = 0;
        do begin @(negedge clk); k++; end while (cnt != v && k < 3000);
        if (cnt != v) chk("wait_cnt_timeout", cnt, v);
    endtask
    task automatic wait_wrap();
        int k = 0;
        do begin @(negedge clk); k++; end while (!wrap && k < 3000);
        if (!wrap) chk("wait_wrap_timeout", 0, 1);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (100) @(negedge clk);
        chk("idle_cnt", cnt, 0);
        chk("idle_ready", cfg_ready, 1);
        chk("idle_n1", n1_out, 0);
        send(10, 200);
        chk("start_n1", n1_out, 10);
        chk("start_n2", n2_out, 200);
        repeat (4) @(negedge clk);
        chk("first_tick", cnt, 1);
        wait_cnt(50);
        send(20, 100);
        chk("pend_ready", cfg_ready, 0);
        chk("pend_hold_n1", n1_out, 10);
        wait_wrap();
        chk("wrap_cnt", cnt, 0);
        chk("wrap_n1", n1_out, 20);
        chk("wrap_n2", n2_out, 100);
        send(150, 30);
        chk("err_pulse", cfg_err, 1);
        chk("err_ready", cfg_ready, 1);
        @(negedge clk);
        chk("err_one_cycle", cfg_err, 0);
        send(77, 77);
        chk("eq_accept", cfg_ready, 0);
        wait_wrap();
        chk("eq_n1", n1_out, 77);
        wait_cnt(255);
        repeat (2) @(negedge clk);
        send(5, 6);
        chk("edge_wrap", wrap, 1);
        chk("edge_ready", cfg_ready, 0);
        chk("edge_n1_old", n1_out, 77);
        wait_wrap();
        chk("edge_n1_new", n1_out, 5);
        wait_cnt(100);
        @(negedge clk);
        run = 0;
        hold = cnt;
        repeat (300) @(negedge clk);
        chk("freeze_cnt", cnt, hold);
        run = 1;
        repeat (4000) begin
            @(negedge clk);
            run = ($urandom % 10) != 0;
            cfg_valid = ($urandom % 50) == 0;
            n1_in = 8'($urandom);
            n2_in = 8'($urandom);
        end
        @(negedge clk);
        cfg_valid = 0; run = 1;
        wait_wrap();
        send(30, 40);
        wait_cnt(128);
        chk("rst_pend", cfg_ready, 0);
        #2 rst = 1;
        #1;
        chk("rst_cnt", cnt, 0);
        chk("rst_n1", n1_out, 0);
        chk("rst_ready", cfg_ready, 1);
        @(negedge clk);
        rst = 0;
        repeat (20) @(negedge clk);
        send(9, 9);
        chk("post_rst_idle_load", n1_out, 9);
        repeat (200) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
